// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and the F/D register view.
interface fetch_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned PC_BITS = 5
);
  logic               stall_f;
  logic               stall_d;
  logic               ex_taken;
  logic [PC_BITS-1:0] ex_target;
  logic [PC_BITS-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic [PC_BITS-1:0] f_pc;
  logic [XLEN-1:0]    f_inst;
  logic [PC_BITS-1:0] d_pc;
  logic [XLEN-1:0]    d_inst;
  logic               d_valid;

  modport master (
    input  stall_f, stall_d, ex_taken, ex_target, imem_rdata,
    output imem_addr, f_pc, f_inst, d_pc, d_inst, d_valid
  );

  modport slave (
    output stall_f, stall_d, ex_taken, ex_target, imem_rdata,
    input  imem_addr, f_pc, f_inst, d_pc, d_inst, d_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction fetch, F/D pipeline register, redirect/stall/flush handling
// and end-of-program detection with a fixed drain before the sticky halted flag.
module fetch_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned PC_BITS      = 5,
  parameter int unsigned HALT_PC      = 22,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic        clk,
  input  logic        rst,
  fetch_if.master     bus,
  output logic        halted,
  output logic [31:0] fetch_cnt
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] d_pc_q, d_pc_d;
  logic [XLEN-1:0]    d_inst_q, d_inst_d;
  logic               d_valid_q, d_valid_d;
  logic [1:0]         state_q, state_d;
  logic [DrainW-1:0]  drain_q, drain_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               halt_detect;
  logic               load_fd;

  assign bus.imem_addr = pc_q;
  assign bus.f_pc      = pc_q;
  assign bus.f_inst    = bus.imem_rdata;
  assign bus.d_pc      = d_pc_q;
  assign bus.d_inst    = d_inst_q;
  assign bus.d_valid   = d_valid_q;
  assign halted        = (state_q == ST_HALTED);
  assign fetch_cnt     = cnt_q;

  // The terminating zero word is neither loaded into F/D nor counted.
  assign halt_detect = (state_q == ST_RUN) && !bus.ex_taken && !bus.stall_f &&
                       (32'(pc_q) >= HALT_PC) && (bus.imem_rdata == '0);
  assign load_fd     = (state_q == ST_RUN) && !bus.ex_taken && !bus.stall_d && !halt_detect;

  always_comb begin
    pc_d      = pc_q;
    d_pc_d    = d_pc_q;
    d_inst_d  = d_inst_q;
    d_valid_d = d_valid_q;
    state_d   = state_q;
    drain_d   = drain_q;
    cnt_d     = cnt_q;

    if (bus.ex_taken) begin
      if (state_q != ST_HALTED) pc_d = bus.ex_target;
    end else if (!bus.stall_f && state_q == ST_RUN && !halt_detect) begin
      pc_d = pc_q + PC_BITS'(1);
    end

    if (bus.ex_taken || (!bus.stall_d && !load_fd)) begin
      d_pc_d    = '0;
      d_inst_d  = '0;
      d_valid_d = 1'b0;
    end else if (load_fd) begin
      d_pc_d    = pc_q;
      d_inst_d  = bus.imem_rdata;
      d_valid_d = 1'b1;
    end

    if (load_fd && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;

    unique case (state_q)
      ST_RUN: begin
        if (halt_detect) begin
          state_d = ST_DRAIN;
          drain_d = DrainW'(DRAIN_CYCLES - 1);
        end
      end
      ST_DRAIN: begin
        // A still-in-flight older branch means the zero word was on a wrong path.
        if (bus.ex_taken) begin
          state_d = ST_RUN;
        end else if (drain_q == '0) begin
          state_d = ST_HALTED;
        end else begin
          drain_d = drain_q - DrainW'(1);
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= '0;
      d_pc_q    <= '0;
      d_inst_q  <= '0;
      d_valid_q <= 1'b0;
      state_q   <= ST_RUN;
      drain_q   <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      d_pc_q    <= d_pc_d;
      d_inst_q  <= d_inst_d;
      d_valid_q <= d_valid_d;
      state_q   <= state_d;
      drain_q   <= drain_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free run to halt, vector table for redirect/stall/NOP cases,
// halt cancellation, PC wrap and reset during drain.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_a, rst_b;
  logic        halted_a, halted_b;
  logic [31:0] cnt_a, cnt_b;
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_if #(.XLEN(32), .PC_BITS(5)) bus_a ();
  fetch_if #(.XLEN(32), .PC_BITS(5)) bus_b ();

  assign bus_a.imem_rdata = mem_a[bus_a.imem_addr];
  assign bus_b.imem_rdata = mem_b[bus_b.imem_addr];

  fetch_stage #(.XLEN(32), .PC_BITS(5), .HALT_PC(22), .DRAIN_CYCLES(5)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (bus_a),
    .halted    (halted_a),
    .fetch_cnt (cnt_a)
  );

  fetch_stage #(.XLEN(32), .PC_BITS(5), .HALT_PC(31), .DRAIN_CYCLES(5)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (bus_b),
    .halted    (halted_b),
    .fetch_cnt (cnt_b)
  );

  typedef struct {
    logic        sf;
    logic        sd;
    logic        ex;
    logic [4:0]  tgt;
    logic [4:0]  pc;
    logic [4:0]  dpc;
    logic [31:0] dinst;
    logic        dv;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt [18];

  function automatic logic [31:0] m(int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic sf, input logic sd, input logic ex, input logic [4:0] tgt);
    bus_a.stall_f   = sf;
    bus_a.stall_d   = sd;
    bus_a.ex_taken  = ex;
    bus_a.ex_target = tgt;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_a[i] = m(i);
      mem_b[i] = m(i) | 32'h0B00_0000;
    end
    mem_a[22] = 32'h0;
    drive_a(1'b0, 1'b0, 1'b0, 5'd0);
    bus_b.stall_f = 1'b0; bus_b.stall_d = 1'b0; bus_b.ex_taken = 1'b0; bus_b.ex_target = 5'd0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;

    // T1: reset state, free run to end-of-program
    step();
    chk("reset pc", 32'(bus_a.f_pc), 32'd0);
    chk("reset imem_addr", 32'(bus_a.imem_addr), 32'd0);
    chk("reset d_valid", 32'(bus_a.d_valid), 32'd0);
    chk("reset d_inst", bus_a.d_inst, 32'd0);
    chk("reset halted", 32'(halted_a), 32'd0);
    chk("reset fetch_cnt", cnt_a, 32'd0);
    chk("f_inst comb", bus_a.f_inst, m(0));
    rst_a = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk($sformatf("t1 pc %0d", k), 32'(bus_a.f_pc), 32'(k));
      chk($sformatf("t1 d_pc %0d", k), 32'(bus_a.d_pc), 32'(k - 1));
      chk($sformatf("t1 d_inst %0d", k), bus_a.d_inst, m(k - 1));
      chk($sformatf("t1 d_valid %0d", k), 32'(bus_a.d_valid), 32'd1);
      chk($sformatf("t1 cnt %0d", k), cnt_a, 32'(k));
    end
    step();
    chk("t1 drain entry d_valid", 32'(bus_a.d_valid), 32'd0);
    chk("t1 drain entry d_inst", bus_a.d_inst, 32'd0);
    chk("t1 drain entry pc", 32'(bus_a.f_pc), 32'd22);
    for (int k = 0; k < 4; k++) step();
    chk("t1 halted before drain end", 32'(halted_a), 32'd0);
    step();
    chk("t1 halted", 32'(halted_a), 32'd1);
    chk("t1 fetch_cnt", cnt_a, 32'd22);
    chk("t1 pc hold", 32'(bus_a.f_pc), 32'd22);
    drive_a(1'b0, 1'b0, 1'b1, 5'd3);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 5'd0);
    chk("halted ignores ex pc", 32'(bus_a.f_pc), 32'd22);
    chk("halted ignores ex state", 32'(halted_a), 32'd1);
    chk("halted bubble", 32'(bus_a.d_valid), 32'd0);

    // T2/T3/T4 vector table (imem[10]=0 is an early NOP)
    mem_a[10] = 32'h0;
    vt[0]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd1,  5'd0,  m(0),  1'b1, 32'd1};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd2,  5'd1,  m(1),  1'b1, 32'd2};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd3,  5'd2,  m(2),  1'b1, 32'd3};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd4,  5'd3,  m(3),  1'b1, 32'd4};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 5'd7, 5'd7,  5'd0,  32'd0, 1'b0, 32'd4};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd8,  5'd7,  m(7),  1'b1, 32'd5};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 5'd4, 5'd4,  5'd0,  32'd0, 1'b0, 32'd5};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd5,  5'd4,  m(4),  1'b1, 32'd6};
    vt[8]  = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd5,  5'd4,  m(4),  1'b1, 32'd6};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd5,  5'd4,  m(4),  1'b1, 32'd6};
    vt[10] = '{1'b1, 1'b1, 1'b0, 5'd0, 5'd5,  5'd4,  m(4),  1'b1, 32'd6};
    vt[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd6,  5'd5,  m(5),  1'b1, 32'd7};
    vt[12] = '{1'b0, 1'b0, 1'b1, 5'd9, 5'd9,  5'd0,  32'd0, 1'b0, 32'd7};
    vt[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd10, 5'd9,  m(9),  1'b1, 32'd8};
    vt[14] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd11, 5'd10, 32'd0, 1'b1, 32'd9};
    vt[15] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd12, 5'd11, m(11), 1'b1, 32'd10};
    vt[16] = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd12, 5'd12, m(12), 1'b1, 32'd11};
    vt[17] = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd13, 5'd12, m(12), 1'b1, 32'd11};

    rst_a = 1'b0;
    step();
    rst_a = 1'b1;
    for (int r = 0; r < 18; r++) begin
      drive_a(vt[r].sf, vt[r].sd, vt[r].ex, vt[r].tgt);
      step();
      chk($sformatf("vec%0d pc", r), 32'(bus_a.f_pc), 32'(vt[r].pc));
      chk($sformatf("vec%0d d_pc", r), 32'(bus_a.d_pc), 32'(vt[r].dpc));
      chk($sformatf("vec%0d d_inst", r), bus_a.d_inst, vt[r].dinst);
      chk($sformatf("vec%0d d_valid", r), 32'(bus_a.d_valid), 32'(vt[r].dv));
      chk($sformatf("vec%0d cnt", r), cnt_a, vt[r].cnt);
      chk($sformatf("vec%0d halted", r), 32'(halted_a), 32'd0);
    end
    drive_a(1'b0, 1'b0, 1'b0, 5'd0);

    // T5: branch on 2nd drain cycle cancels halt
    drive_a(1'b0, 1'b0, 1'b1, 5'd21);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 5'd0);
    step();
    chk("t5 pc22", 32'(bus_a.f_pc), 32'd22);
    step();
    chk("t5 drain bubble", 32'(bus_a.d_valid), 32'd0);
    step();
    drive_a(1'b0, 1'b0, 1'b1, 5'd3);
    step();
    drive_a(1'b0, 1'b0, 1'b0, 5'd0);
    chk("t5 cancel pc", 32'(bus_a.f_pc), 32'd3);
    chk("t5 cancel flush", 32'(bus_a.d_valid), 32'd0);
    step();
    chk("t5 resume pc", 32'(bus_a.f_pc), 32'd4);
    chk("t5 resume d_pc", 32'(bus_a.d_pc), 32'd3);
    chk("t5 resume d_valid", 32'(bus_a.d_valid), 32'd1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("t5 no halt %0d", k), 32'(halted_a), 32'd0);
    end
    chk("t5 running pc", 32'(bus_a.f_pc), 32'd12);

    // T6: HALT_PC=31 instance, PC wrap then reset while draining
    step();
    rst_b = 1'b1;
    for (int k = 0; k < 31; k++) step();
    chk("t6 pc31", 32'(bus_b.f_pc), 32'd31);
    chk("t6 no halt at 31", 32'(halted_b), 32'd0);
    step();
    chk("t6 wrap pc", 32'(bus_b.f_pc), 32'd0);
    chk("t6 wrap d_pc", 32'(bus_b.d_pc), 32'd31);
    chk("t6 wrap cnt", cnt_b, 32'd32);
    mem_b[31] = 32'h0;
    bus_b.ex_taken = 1'b1; bus_b.ex_target = 5'd30;
    step();
    bus_b.ex_taken = 1'b0; bus_b.ex_target = 5'd0;
    step();
    chk("t6 pc31 again", 32'(bus_b.f_pc), 32'd31);
    step();
    chk("t6 drain bubble", 32'(bus_b.d_valid), 32'd0);
    rst_b = 1'b0;
    step();
    chk("t6 rst pc", 32'(bus_b.f_pc), 32'd0);
    chk("t6 rst d_pc", 32'(bus_b.d_pc), 32'd0);
    chk("t6 rst d_inst", bus_b.d_inst, 32'd0);
    chk("t6 rst d_valid", 32'(bus_b.d_valid), 32'd0);
    chk("t6 rst halted", 32'(halted_b), 32'd0);
    chk("t6 rst cnt", cnt_b, 32'd0);
    rst_b = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("t6 post-rst pc", 32'(bus_b.f_pc), 32'd7);
    chk("t6 post-rst halted", 32'(halted_b), 32'd0);
    chk("t6 post-rst cnt", cnt_b, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
